// File: rtl/hicore_flush_ctrl.sv
// hicore_flush_ctrl: sequences the redirect that follows a commit flush.
// The flush stalls retirement and kills younger work. The controller then
// waits for outstanding LSU bus transactions to drain. For fence.i it
// optionally runs an I-cache invalidate handshake. Finally it hands the
// captured PC to the IFU over a valid/ready redirect handshake.
//
// Optional feature macro: HICORE_FENCEI_INVAL_EN
//   defined   : fence.i flushes run the I-cache invalidate handshake (INVAL).
//   undefined : INVAL is never entered, icache_inval_req is tied low and
//               icache_inval_ack is ignored; fence.i is a plain flush.
module hicore_flush_ctrl #(
    parameter int PC_SIZE = 32,
    parameter int OUTST_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_flush,
    input  logic [PC_SIZE-1:0] commit_flush_pc,
    input  logic               commit_fence_i,
    output logic               commit_stall,
    output logic               pipe_kill,
    input  logic               lsu_req_fire,
    input  logic               lsu_rsp_fire,
    output logic               lsu_req_block,
    output logic               icache_inval_req,
    input  logic               icache_inval_ack,
    output logic               ifu_redirect_valid,
    input  logic               ifu_redirect_ready,
    output logic [PC_SIZE-1:0] ifu_redirect_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_INVAL = 2'd2,
        ST_REDIR = 2'd3
    } state_e;

    localparam logic [OUTST_W-1:0] CNT_MAX  = {OUTST_W{1'b1}};
    localparam logic [OUTST_W-1:0] CNT_ZERO = {OUTST_W{1'b0}};
    localparam logic [OUTST_W-1:0] CNT_ONE  = {{(OUTST_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [OUTST_W-1:0]   outst_cnt_q, outst_cnt_d;
    logic [PC_SIZE-1:0]   pc_q, pc_d;
    logic                 fence_q, fence_d;

`ifndef HICORE_FENCEI_INVAL_EN
    // The acknowledge has no consumer when the invalidate path is not built.
    logic unused_inval_ack_s;
    assign unused_inval_ack_s = icache_inval_ack;
`endif

    // State, counter and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            outst_cnt_q <= CNT_ZERO;
            pc_q        <= {PC_SIZE{1'b0}};
            fence_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            outst_cnt_q <= outst_cnt_d;
            pc_q        <= pc_d;
            fence_q     <= fence_d;
        end
    end

    // Next-state logic; also captures the flush target and fence flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fence_d = fence_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_flush) begin
                    state_d = ST_DRAIN;
                    pc_d    = commit_flush_pc;
                    fence_d = commit_fence_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Exit decision uses the registered count, not this cycle's fires.
                if (outst_cnt_q == CNT_ZERO) begin
`ifdef HICORE_FENCEI_INVAL_EN
                    if (fence_q) begin
                        state_d = ST_INVAL;
                    end else begin
                        state_d = ST_REDIR;
                    end
`else
                    state_d = ST_REDIR;
                    fence_d = 1'b0;
`endif
                end else begin
                    state_d = ST_DRAIN;
                end
            end
`ifdef HICORE_FENCEI_INVAL_EN
            ST_INVAL: begin
                if (icache_inval_ack) begin
                    state_d = ST_REDIR;
                    fence_d = 1'b0;
                end else begin
                    state_d = ST_INVAL;
                end
            end
`endif
            ST_REDIR: begin
                if (ifu_redirect_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REDIR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fence_d = 1'b0;
            end
        endcase
    end

    // Outstanding LSU transaction counter; saturates at both ends.
    always_comb begin
        outst_cnt_d = outst_cnt_q;
        if (lsu_req_fire && !lsu_rsp_fire) begin
            if (outst_cnt_q != CNT_MAX) begin
                outst_cnt_d = outst_cnt_q + CNT_ONE;
            end else begin
                outst_cnt_d = outst_cnt_q;
            end
        end else if (lsu_rsp_fire && !lsu_req_fire) begin
            // A response with nothing outstanding is a protocol error; hold at zero.
            if (outst_cnt_q != CNT_ZERO) begin
                outst_cnt_d = outst_cnt_q - CNT_ONE;
            end else begin
                outst_cnt_d = outst_cnt_q;
            end
        end else begin
            outst_cnt_d = outst_cnt_q;
        end
    end

    // Output decode from the registered state and count.
    always_comb begin
        commit_stall       = 1'b0;
        pipe_kill          = 1'b0;
        icache_inval_req   = 1'b0;
        ifu_redirect_valid = 1'b0;
        ifu_redirect_pc    = pc_q;
        lsu_req_block      = (state_q != ST_IDLE) || (outst_cnt_q == CNT_MAX);
        case (state_q)
            ST_IDLE: begin
                commit_stall = 1'b0;
                pipe_kill    = 1'b0;
            end
            ST_DRAIN: begin
                commit_stall = 1'b1;
                pipe_kill    = 1'b1;
            end
            ST_INVAL: begin
                commit_stall = 1'b1;
                pipe_kill    = 1'b1;
`ifdef HICORE_FENCEI_INVAL_EN
                icache_inval_req = 1'b1;
`else
                icache_inval_req = 1'b0;
`endif
            end
            ST_REDIR: begin
                commit_stall       = 1'b1;
                pipe_kill          = 1'b1;
                ifu_redirect_valid = 1'b1;
            end
            default: begin
                commit_stall = 1'b1;
                pipe_kill    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_hicore_flush_ctrl.sv
// Self-checking bench for hicore_flush_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_hicore_flush_ctrl;

    localparam int PC_SIZE = 32;
    localparam int OUTST_W = 3;
    localparam int CNT_MAX = (1 << OUTST_W) - 1;
`ifdef HICORE_FENCEI_INVAL_EN
    localparam bit FENCE_EN = 1'b1;
`else
    localparam bit FENCE_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               commit_flush = 1'b0;
    logic [PC_SIZE-1:0] commit_flush_pc = '0;
    logic               commit_fence_i = 1'b0;
    logic               commit_stall;
    logic               pipe_kill;
    logic               lsu_req_fire = 1'b0;
    logic               lsu_rsp_fire = 1'b0;
    logic               lsu_req_block;
    logic               icache_inval_req;
    logic               icache_inval_ack = 1'b0;
    logic               ifu_redirect_valid;
    logic               ifu_redirect_ready = 1'b0;
    logic [PC_SIZE-1:0] ifu_redirect_pc;

    hicore_flush_ctrl #(.PC_SIZE(PC_SIZE), .OUTST_W(OUTST_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .commit_flush       (commit_flush),
        .commit_flush_pc    (commit_flush_pc),
        .commit_fence_i     (commit_fence_i),
        .commit_stall       (commit_stall),
        .pipe_kill          (pipe_kill),
        .lsu_req_fire       (lsu_req_fire),
        .lsu_rsp_fire       (lsu_rsp_fire),
        .lsu_req_block      (lsu_req_block),
        .icache_inval_req   (icache_inval_req),
        .icache_inval_ack   (icache_inval_ack),
        .ifu_redirect_valid (ifu_redirect_valid),
        .ifu_redirect_ready (ifu_redirect_ready),
        .ifu_redirect_pc    (ifu_redirect_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one pending flush described by what it still waits for.
    bit          m_busy;
    bit          m_drained;
    bit          m_need_inval;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_block();
        return m_busy || (m_cnt == CNT_MAX);
    endfunction

    task automatic check_all();
        check_val("commit_stall", {31'd0, commit_stall}, {31'd0, m_busy});
        check_val("pipe_kill", {31'd0, pipe_kill}, {31'd0, m_busy});
        check_val("lsu_req_block", {31'd0, lsu_req_block}, {31'd0, exp_block()});
        check_val("icache_inval_req", {31'd0, icache_inval_req},
                  {31'd0, m_busy && m_drained && m_need_inval});
        check_val("redirect_valid", {31'd0, ifu_redirect_valid},
                  {31'd0, m_busy && m_drained && !m_need_inval});
        check_val("redirect_pc", ifu_redirect_pc, m_pc);
    endtask

    // Advance the model by one clock using the inputs applied in that cycle.
    task automatic model_clock(input bit r, input bit f, input bit fi, input logic [31:0] pc,
                               input bit rq, input bit rs, input bit ack, input bit rdy);
        int old_cnt;
        old_cnt = m_cnt;
        if (r) begin
            m_busy = 1'b0; m_drained = 1'b0; m_need_inval = 1'b0; m_pc = 32'd0; m_cnt = 0;
        end else begin
            if (rq && !rs && m_cnt != CNT_MAX) m_cnt = m_cnt + 1;
            else if (rs && !rq && m_cnt != 0) m_cnt = m_cnt - 1;
            if (m_busy) begin
                if (!m_drained) begin
                    if (old_cnt == 0) m_drained = 1'b1;
                end else if (m_need_inval) begin
                    if (ack) m_need_inval = 1'b0;
                end else if (rdy) begin
                    m_busy = 1'b0;
                end
            end else if (f) begin
                m_busy = 1'b1;
                m_drained = 1'b0;
                m_need_inval = fi && FENCE_EN;
                m_pc = pc;
            end
        end
    endtask

    // Apply one cycle of inputs, clock, then compare at the falling edge.
    task automatic step(input bit r, input bit f, input bit fi, input logic [31:0] pc,
                        input bit rq, input bit rs, input bit ack, input bit rdy);
        rst = r; commit_flush = f; commit_fence_i = fi; commit_flush_pc = pc;
        lsu_req_fire = rq; lsu_rsp_fire = rs; icache_inval_ack = ack; ifu_redirect_ready = rdy;
        @(posedge clk);
        model_clock(r, f, fi, pc, rq, rs, ack, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        m_busy = 1'b0; m_drained = 1'b0; m_need_inval = 1'b0; m_pc = 32'd0; m_cnt = 0;
        @(negedge clk);
        // Reset, then quiet idle.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        // Fill the counter to saturation, then drain and over-respond at zero.
        for (int i = 0; i < CNT_MAX; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 2; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Simultaneous request and response leave the count unchanged.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Plain flush, nothing outstanding, IFU ready.
        step(1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        // Flush with two outstanding; responses at t+3 and t+5.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0180, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++)
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, (i == 3) || (i == 5), 1'b0, 1'b1);
        // fence.i flush with acknowledge at t+6.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++)
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, (i == 6), 1'b1);
        // Redirect held off by ready low for three cycles; flush ignored while busy.
        step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEE0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++)
            step(1'b0, (i == 3), 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, (i >= 5));
        // Reset in the middle of a fence sequence, then a normal flush.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, f, fi, rq, rs, ack, rdy;
            logic [31:0] pc;
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 9) == 0);
            fi  = ($urandom_range(0, 1) == 1);
            pc  = $urandom;
            rq  = !exp_block() && ($urandom_range(0, 2) == 0);
            rs  = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            ack = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            step(r, f, fi, pc, rq, rs, ack, rdy);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
